spi_burst_sequencer: RTL and testbench

Upstream companion to the SPI controller top. Buffers host write bytes in a TX FIFO and runs multi-byte bursts under one chip-select window. Hands each byte to the controller over its tx/tx_valid/ready handshake, then returns every received byte to the host as a one-cycle strobe. The controller has no chip-select, so this block owns CS_n timing.

---
 rtl/spi_seq_pkg.sv | 20 ++
 rtl/spi_tx_fifo.sv | 56 +++++
 rtl/spi_burst_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI burst sequencer and its TX FIFO.
package spi_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int CFG_W  = 11;

  // Byte sent when a burst needs data but the host has not supplied any.
  localparam logic [BYTE_W-1:0] FILLER_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    ISSUE,
    WAIT_RX,
    WAIT_RDY,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO holding host bytes until the sequencer hands them to the
// SPI controller. DEPTH must be a power of two so the pointers wrap for free.
module spi_tx_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [BYTE_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A push into a full FIFO still fits when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed since the level gates every read.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer sitting in front of the SPI controller: owns chip-select
// timing, feeds bytes from the TX FIFO over the controller's tx/valid/ready
// handshake and returns each received byte to the host as a strobe.
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [CFG_W-1:0]        i_cfg,
  input  logic [7:0]              i_len,
  input  logic                    i_start,
  input  logic [BYTE_W-1:0]       i_wr_data,
  input  logic                    i_wr_en,
  output logic [$clog2(DEPTH):0]  o_tx_level,
  output logic                    o_overflow,
  output logic                    o_underrun,
  output logic [BYTE_W-1:0]       o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CFG_W-1:0]        o_spi_config,
  output logic [BYTE_W-1:0]       o_spi_tx,
  output logic                    o_spi_tx_valid,
  input  logic [BYTE_W-1:0]       i_spi_rx,
  input  logic                    i_spi_rx_valid,
  input  logic                    i_spi_ready,
  output logic                    o_cs_n
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rem_q, rem_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [BYTE_W-1:0]  tx_q, tx_d;
  logic               tx_valid_q, tx_valid_d;
  logic               cs_n_q, cs_n_d;
  logic [BYTE_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               underrun_q, underrun_d;
  logic               done_q, done_d;
  logic               overflow_q;

  logic               fifo_pop;
  logic [BYTE_W-1:0]  fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;

  assign fifo_pop = (state_q == LOAD) && !fifo_empty;

  spi_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (i_wr_en),
    .wr_data (i_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_tx_level)
  );

  // Drop pulse is registered so it lands the cycle after the rejected push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) overflow_q <= 1'b0;
    else          overflow_q <= i_wr_en && fifo_full && !fifo_pop;
  end

  // FSM state and every registered output; reset releases CS_n immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      cfg_q      <= '0;
      tx_q       <= '0;
      tx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      cfg_q      <= cfg_d;
      tx_q       <= tx_d;
      tx_valid_q <= tx_valid_d;
      cs_n_q     <= cs_n_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  // Next-state and output decode; pulses default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    cfg_d      = cfg_q;
    tx_d       = tx_q;
    tx_valid_d = tx_valid_q;
    cs_n_d     = cs_n_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && (i_len != 8'd0) && i_spi_ready) begin
          state_d = SETUP;
          cfg_d   = i_cfg;
          rem_d   = i_len;
          cs_n_d  = 1'b0;
          cnt_d   = CNT_W'(CS_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      LOAD: begin
        if (fifo_empty) begin
          tx_d       = FILLER_BYTE;
          underrun_d = 1'b1;
        end else begin
          tx_d = fifo_rd_data;
        end
        tx_valid_d = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        // Ready falls late through the controller's synchronizer, so keep
        // presenting the byte until the drop is actually seen.
        if (!i_spi_ready) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (i_spi_rx_valid) begin
          rd_data_d  = i_spi_rx;
          rd_valid_d = 1'b1;
          rem_d      = rem_q - 1'b1;
          state_d    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_spi_ready) begin
          if (rem_q == 8'd0) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(CS_HOLD - 1);
          end else begin
            state_d = LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy         = (state_q != IDLE);
  assign o_spi_config   = cfg_q;
  assign o_spi_tx       = tx_q;
  assign o_spi_tx_valid = tx_valid_q;
  assign o_cs_n         = cs_n_q;
  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_underrun     = underrun_q;
  assign o_done         = done_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Self-checking bench: a host-level FIFO/burst model predicts transmitted and
// received bytes into queues; a controller model and a monitor consume them.
module tb_spi_burst_sequencer;

  localparam int DEPTH    = 16;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [10:0] i_cfg = '0;
  logic [7:0]  i_len = '0;
  logic        i_start = 1'b0;
  logic [7:0]  i_wr_data = '0;
  logic        i_wr_en = 1'b0;
  logic [4:0]  o_tx_level;
  logic        o_overflow;
  logic        o_underrun;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_busy;
  logic        o_done;
  logic [10:0] o_spi_config;
  logic [7:0]  o_spi_tx;
  logic        o_spi_tx_valid;
  logic [7:0]  i_spi_rx = '0;
  logic        i_spi_rx_valid = 1'b0;
  logic        i_spi_ready = 1'b1;
  logic        o_cs_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] fifo_model[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];

  int exp_done = 0, exp_underrun = 0, exp_overflow = 0;
  int done_count = 0, underrun_count = 0, overflow_count = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, cs_rises = 0, txv_first_cyc = 0, done_cyc = 0;
  int last_ready_cyc = 0;
  int tx_count = 0;
  int drop_mode = 0;
  bit txv_pending = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_txv = 1'b0;

  always #5 i_clk = ~i_clk;

  spi_burst_sequencer #(
    .DEPTH    (DEPTH),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cfg          (i_cfg),
    .i_len          (i_len),
    .i_start        (i_start),
    .i_wr_data      (i_wr_data),
    .i_wr_en        (i_wr_en),
    .o_tx_level     (o_tx_level),
    .o_overflow     (o_overflow),
    .o_underrun     (o_underrun),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_spi_config   (o_spi_config),
    .o_spi_tx       (o_spi_tx),
    .o_spi_tx_valid (o_spi_tx_valid),
    .i_spi_rx       (i_spi_rx),
    .i_spi_rx_valid (i_spi_rx_valid),
    .i_spi_ready    (i_spi_ready),
    .o_cs_n         (o_cs_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Cycle index, advanced at each rising edge.
  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  // Monitor: timestamps CS/valid edges, counts pulses, scores returned bytes.
  initial forever begin
    @(negedge i_clk);
    if (prev_cs && !o_cs_n) begin
      cs_fall_cyc = cyc;
      txv_pending = 1'b1;
    end
    if (!prev_cs && o_cs_n) begin
      cs_rise_cyc = cyc;
      cs_rises++;
    end
    if (o_spi_tx_valid && !prev_txv && txv_pending) begin
      txv_first_cyc = cyc;
      txv_pending = 1'b0;
    end
    if (o_done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (o_underrun) underrun_count++;
    if (o_overflow) overflow_count++;
    if (o_rd_valid) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_unexpected: got 0x%0h, expected no strobe at cycle %0d", o_rd_data, cyc);
      end else begin
        checkOutput("rd_data", o_rd_data, exp_rd.pop_front());
      end
    end
    prev_cs = o_cs_n;
    prev_txv = o_spi_tx_valid;
  end

  // Controller model: accepts a byte, drops ready after a delay, returns the
  // bitwise inverse, then raises ready again.
  initial begin : controller_model
    logic [7:0] b;
    int d;
    int xfer;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_spi_tx_valid && i_spi_ready) begin
        b = o_spi_tx;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no byte at cycle %0d", b, cyc);
        end else begin
          checkOutput("tx_byte", b, exp_tx.pop_front());
        end
        d = (drop_mode == 0) ? $urandom_range(1, 4) : drop_mode;
        repeat (d - 1) begin
          @(negedge i_clk);
          checkOutput("txv_held", {o_spi_tx_valid, o_spi_tx}, {1'b1, b});
        end
        @(posedge i_clk);
        #1 i_spi_ready = 1'b0;
        tx_count++;
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("txv_drop", o_spi_tx_valid, 0);
        xfer = $urandom_range(1, 4);
        repeat (xfer) @(posedge i_clk);
        #1;
        i_spi_rx = ~b;
        i_spi_rx_valid = 1'b1;
        @(posedge i_clk);
        #1 i_spi_rx_valid = 1'b0;
        @(posedge i_clk);
        #1 i_spi_ready = 1'b1;
        last_ready_cyc = cyc;
      end
    end
  end

  task automatic pushOne(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b1;
    i_wr_data = b;
    if (fifo_model.size() < DEPTH) fifo_model.push_back(b);
    else exp_overflow++;
    @(posedge i_clk);
    #1 i_wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) pushOne(8'($urandom_range(0, 255)));
  endtask

  // Predict a burst of len bytes from the host FIFO model.
  task automatic predictBurst(input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      if (fifo_model.size() > 0) b = fifo_model.pop_front();
      else begin
        b = 8'h00;
        exp_underrun++;
      end
      exp_tx.push_back(b);
      exp_rd.push_back(~b);
    end
  endtask

  task automatic runBurst(input int len, input int mode, input bit busy_start);
    logic [10:0] cfg;
    int start_cyc;
    drop_mode = mode;
    predictBurst(len);
    exp_done++;
    cs_rises = 0;
    cfg = 11'($urandom_range(1, 2047));
    @(posedge i_clk);
    #1;
    i_cfg = cfg;
    i_len = 8'(len);
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_cfg = ~cfg;
    @(negedge i_clk);
    checkOutput("cfg_latched", o_spi_config, cfg);
    if (busy_start) begin
      repeat (2) @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_len = 8'd7;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      @(negedge i_clk);
      checkOutput("busy_start_ignored", {o_busy, o_cs_n}, 2'b10);
    end
    for (int i = 0; i < 3000 && done_count < exp_done; i++) @(negedge i_clk);
    checkOutput("done_seen", done_count, exp_done);
    checkOutput("cs_fall_latency", cs_fall_cyc - start_cyc, 1);
    checkOutput("txv_first_latency", txv_first_cyc - cs_fall_cyc, CS_SETUP + 1);
    // Ready is driven just after an edge, so the DUT samples it one edge later.
    checkOutput("cs_hold_latency", cs_rise_cyc - last_ready_cyc, CS_HOLD + 1);
    checkOutput("done_with_cs_rise", done_cyc, cs_rise_cyc);
    checkOutput("cs_single_window", cs_rises, 1);
    checkOutput("tx_all_sent", exp_tx.size(), 0);
    checkOutput("rd_all_returned", exp_rd.size(), 0);
    checkOutput("underrun_count", underrun_count, exp_underrun);
    checkOutput("cfg_held", o_spi_config, cfg);
    checkOutput("level_after", o_tx_level, fifo_model.size());
    repeat (4) @(negedge i_clk);
    checkOutput("idle_after", {o_busy, o_cs_n}, 2'b01);
    checkOutput("no_extra_done", done_count, exp_done);
  endtask

  initial begin
    logic cs_before;
    int target;
    $display("[TB] start");
    #12;
    checkOutput("rst_cs_n", o_cs_n, 1);
    checkOutput("rst_config", o_spi_config, 0);
    checkOutput("rst_tx", o_spi_tx, 0);
    checkOutput("rst_pulses", {o_spi_tx_valid, o_busy, o_done, o_rd_valid, o_underrun, o_overflow}, 0);
    checkOutput("rst_level", o_tx_level, 0);
    checkOutput("rst_rd_data", o_rd_data, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // Two host bytes echoed back inverted.
    pushOne(8'hA5);
    pushOne(8'h3C);
    @(negedge i_clk);
    checkOutput("level_two", o_tx_level, 2);
    runBurst(2, 0, 1'b0);

    // Empty FIFO: three filler bytes.
    runBurst(3, 0, 1'b0);

    // Overfill: 17th push dropped.
    applyStimulus(DEPTH + 1);
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("level_full", o_tx_level, DEPTH);
    checkOutput("overflow_count", overflow_count, exp_overflow);
    runBurst(DEPTH, 0, 1'b0);

    // Zero-length start is ignored.
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_len = 8'd0;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("len0_ignored", {o_busy, o_cs_n}, 2'b01);
    checkOutput("len0_no_done", done_count, exp_done);

    // Start while busy is ignored.
    runBurst(3, 0, 1'b1);

    // Ready drop delayed three cycles after valid.
    applyStimulus(2);
    runBurst(2, 3, 1'b0);

    // Reset during the second byte of a four-byte burst.
    applyStimulus(4);
    drop_mode = 0;
    predictBurst(4);
    target = tx_count + 2;
    @(posedge i_clk);
    #1;
    i_len = 8'd4;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int i = 0; i < 500 && !(tx_count >= target && !i_spi_ready); i++) @(negedge i_clk);
    checkOutput("reached_byte2", tx_count, target);
    @(posedge i_clk);
    #1 cs_before = o_cs_n;
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("cs_low_before_reset", cs_before, 0);
    checkOutput("rst_mid_cs_n", o_cs_n, 1);
    checkOutput("rst_mid_busy", o_busy, 0);
    checkOutput("rst_mid_level", o_tx_level, 0);
    exp_tx.delete();
    exp_rd.delete();
    fifo_model.delete();
    for (int i = 0; i < 100 && !i_spi_ready; i++) @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    checkOutput("rst_mid_no_done", done_count, exp_done);
    applyStimulus(3);
    runBurst(3, 0, 1'b0);

    // Randomized bursts with mixed push counts and lengths.
    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom_range(0, DEPTH - fifo_model.size()));
      @(negedge i_clk);
      checkOutput("level_random", o_tx_level, fifo_model.size());
      runBurst($urandom_range(1, 20), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
